bcd_stopwatch: RTL

//  Parametrised multi-digit BCD stopwatch with a synchronous single-clock counter.
//  - Prescaler generates a count tick; count held directly in BCD digits.
//  - Start/stop, clear, lap hold and up/down direction controls.
//  - Time-multiplexed seven-segment scan output; replaces ripple-clocked counter blocks.

---
 rtl/stopwatch_pkg.sv | 25 ++
 rtl/bcd_digit.sv | 27 ++
 rtl/bcd_stopwatch.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the BCD stopwatch: run-state encoding, seven-segment
// glyph table and a BCD conversion helper used for elaboration-time constants.
package stopwatch_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} sw_state_t;

    // Segments {g,f,e,d,c,b,a}, active-high; A..F give hex glyphs.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [31:0] to_bcd(input int value);
        logic [31:0] r;
        int          t;
        r = '0;
        t = value;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit: load has priority over count; cout flags the 9->0 carry or
// 0->9 borrow so the next digit counts on the same tick.
module bcd_digit (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] q,
    output logic       cout
);

    assign cout = en & (up ? (q == 4'd9) : (q == 4'd0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= 4'd0;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            if (up) q <= (q == 4'd9) ? 4'd0 : q + 4'd1;
            else    q <= (q == 4'd0) ? 4'd9 : q - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_stopwatch.sv
// Multi-digit BCD stopwatch: synchronised buttons, run/pause FSM, prescaled tick,
// lap freeze and a registered seven-segment scanner driving an/seg together.
module bcd_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int LIMIT    = 20,
    parameter int TICK_DIV = 1000000,
    parameter int SCAN_DIV = 50000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_stop,
    input  logic                clear,
    input  logic                lap,
    input  logic                dir,
    output logic [4*DIGITS-1:0] count_bcd,
    output logic                running,
    output logic                wrap,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   an
);

    localparam int CW = 4 * DIGITS;
    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [31:0]       LIMIT_FULL = to_bcd(LIMIT - 1);
    localparam logic [CW-1:0]     TOP_BCD    = LIMIT_FULL[CW-1:0];
    localparam logic [PW-1:0]     PRESC_MAX  = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0]     SCAN_MAX   = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]     IDX_MAX    = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_ONE     = DIGITS'(1);

    // [0] first sync flop, [1] second sync flop, [2] previous sample for edge detect
    logic [2:0] ss_q, clr_q, lap_q;
    logic [1:0] dir_q;
    logic       ss_edge, clr_edge, lap_edge, dir_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ss_q  <= '0;
            clr_q <= '0;
            lap_q <= '0;
            dir_q <= '0;
        end else begin
            ss_q  <= {ss_q[1:0], start_stop};
            clr_q <= {clr_q[1:0], clear};
            lap_q <= {lap_q[1:0], lap};
            dir_q <= {dir_q[0], dir};
        end
    end

    assign ss_edge  = ss_q[1] & ~ss_q[2];
    assign clr_edge = clr_q[1] & ~clr_q[2];
    assign lap_edge = lap_q[1] & ~lap_q[2];
    assign dir_s    = dir_q[1];

    sw_state_t state_q, state_d;
    logic      cnt_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Clear overrides a simultaneous start/stop edge.
    always_comb begin
        state_d = state_q;
        if (clr_edge) begin
            state_d = IDLE;
        end else if (ss_edge) begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_en = (state_q == RUN);
    end

    logic [PW-1:0] presc;
    logic          tick;

    assign tick = cnt_en && (presc == PRESC_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)         presc <= '0;
        else if (clr_edge) presc <= '0;
        else if (cnt_en)   presc <= tick ? '0 : presc + 1'b1;
    end

    logic [DIGITS:0] chain;
    logic [CW-1:0]   load_vec;
    logic            at_bound, do_wrap, load;

    // A full-width carry/borrow out of the top digit also counts as a wrap.
    assign at_bound = dir_s ? (count_bcd == '0) : (count_bcd == TOP_BCD);
    assign do_wrap  = (tick & at_bound) | chain[DIGITS];
    assign load     = clr_edge | do_wrap;
    assign load_vec = (!clr_edge && dir_s) ? TOP_BCD : '0;
    assign chain[0] = tick;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk      (clk),
            .reset    (reset),
            .en       (chain[g]),
            .up       (~dir_s),
            .load     (load),
            .load_val (load_vec[4*g +: 4]),
            .q        (count_bcd[4*g +: 4]),
            .cout     (chain[g+1])
        );
    end

    logic          lap_hold;
    logic [CW-1:0] snapshot;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lap_hold <= 1'b0;
            snapshot <= '0;
        end else if (clr_edge) begin
            lap_hold <= 1'b0;
        end else if (lap_edge && state_q != IDLE) begin
            lap_hold <= ~lap_hold;
            if (!lap_hold) snapshot <= count_bcd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            running <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            running <= (state_d == RUN);
            wrap    <= do_wrap & ~clr_edge;
        end
    end

    logic [SW-1:0] scan_cnt;
    logic [IW-1:0] idx;
    logic [CW-1:0] disp, disp_sh;

    assign disp    = lap_hold ? snapshot : count_bcd;
    assign disp_sh = disp >> {idx, 2'b00};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt <= '0;
            idx      <= '0;
            an       <= AN_ONE;
            seg      <= 7'h3F;
        end else begin
            if (scan_cnt == SCAN_MAX) begin
                scan_cnt <= '0;
                idx      <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            an  <= AN_ONE << idx;
            seg <= SEG_LUT[disp_sh[3:0]];
        end
    end

endmodule
